// File: rtl/qos_pkg.sv
// Shared definitions for the QoS block and its traffic injector: FSM encoding
// and default sizing constants.
package qos_pkg;
    localparam int QOS_QUEUE_QUANTITY = 4;
    localparam int QOS_BUF_WIDTH      = 3;
    localparam int QOS_MAX_PALABRAS   = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENVIO  = 2'd1,
        ST_ESPERA = 2'd2,
        ST_FIN    = 2'd3
    } inj_state_t;
endpackage

// File: rtl/qos_inyector_arbitro.sv
// Rotating-priority grant: first set bit of i_mask found scanning upward from
// i_ptr, wrapping modulo QUEUE_QUANTITY.
module qos_inyector_arbitro
    import qos_pkg::*;
#(
    parameter int QUEUE_QUANTITY = QOS_QUEUE_QUANTITY,
    parameter int VW             = $clog2(QOS_QUEUE_QUANTITY)
) (
    input  logic [QUEUE_QUANTITY-1:0] i_mask,
    input  logic [VW-1:0]             i_ptr,
    output logic                      o_vld,
    output logic [VW-1:0]             o_idx
);
    logic [VW-1:0] w_j;

    // Scan from the farthest offset down so the closest candidate to i_ptr wins.
    always_comb begin
        o_vld = 1'b0;
        o_idx = '0;
        w_j   = '0;
        for (int i = QUEUE_QUANTITY - 1; i >= 0; i--) begin
            w_j = VW'((int'(i_ptr) + i) % QUEUE_QUANTITY);
            if (i_mask[w_j]) begin
                o_vld = 1'b1;
                o_idx = w_j;
            end
        end
    end
endmodule

// File: rtl/qos_inyector.sv
// Burst traffic injector feeding the QoS block's virtual channels.
// Optional QOS_INYECTOR_REINTENTO_EN: overflowed writes are resent.
module qos_inyector
    import qos_pkg::*;
#(
    parameter int QUEUE_QUANTITY = QOS_QUEUE_QUANTITY,
    parameter int BUF_WIDTH      = QOS_BUF_WIDTH,
    parameter int MAX_PALABRAS   = QOS_MAX_PALABRAS
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst,
    input  logic                                        i_enb,
    input  logic                                        i_iniciar,
    input  logic [QUEUE_QUANTITY*$clog2(MAX_PALABRAS)-1:0] i_cantidad,
    input  logic [QUEUE_QUANTITY-1:0]                   i_pausa,
    input  logic [QUEUE_QUANTITY-1:0]                   i_continuar,
    input  logic [QUEUE_QUANTITY-1:0]                   i_error_full,
    output logic                                        o_wr_en,
    output logic [$clog2(QUEUE_QUANTITY)-1:0]           o_vc_id,
    output logic [BUF_WIDTH:0]                          o_data_word,
    output logic                                        o_ocupado,
    output logic                                        o_listo,
    output logic [3:0]                                  o_errores
);
    localparam int CW = $clog2(MAX_PALABRAS);
    localparam int VW = $clog2(QUEUE_QUANTITY);
    localparam int DW = BUF_WIDTH + 1;
    localparam logic [CW-1:0] REST_MAX = CW'(MAX_PALABRAS - 1);

    inj_state_t                         r_state, w_state_nx;
    logic [QUEUE_QUANTITY-1:0][CW-1:0]  r_rest, w_rest_nx;
    logic [QUEUE_QUANTITY-1:0][1:0]     r_seq;
    logic [QUEUE_QUANTITY-1:0]          r_pausado;
    logic [VW-1:0]                      r_ptr;
    logic                               r_wr_en;
    logic [VW-1:0]                      r_vc;
    logic [DW-1:0]                      r_data;
    logic [3:0]                         r_err;
    logic [QUEUE_QUANTITY-1:0]          w_elig;
    logic                               w_busy, w_gnt_vld, w_start, w_send;
    logic [VW-1:0]                      w_gnt;

    // A pausa sampled this cycle blocks the VC immediately, before pausado latches.
    always_comb begin
        w_busy = 1'b0;
        w_elig = '0;
        for (int v = 0; v < QUEUE_QUANTITY; v++) begin
            w_elig[v] = (r_rest[v] != '0) && !(r_pausado[v] || i_pausa[v]);
            w_busy    = w_busy || (r_rest[v] != '0);
        end
    end

    qos_inyector_arbitro #(.QUEUE_QUANTITY(QUEUE_QUANTITY), .VW(VW)) u_arbitro (
        .i_mask (w_elig),
        .i_ptr  (r_ptr),
        .o_vld  (w_gnt_vld),
        .o_idx  (w_gnt)
    );

    assign w_start = (r_state == ST_IDLE) && i_iniciar;
    assign w_send  = (r_state == ST_ENVIO) && w_gnt_vld;

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE:   if (i_iniciar) w_state_nx = ST_ENVIO;
            ST_ENVIO:  if (!w_busy) w_state_nx = ST_FIN;
                       else if (!w_gnt_vld) w_state_nx = ST_ESPERA;
            ST_ESPERA: if (!w_busy) w_state_nx = ST_FIN;
                       else if (w_gnt_vld) w_state_nx = ST_ENVIO;
            ST_FIN:    w_state_nx = ST_IDLE;
            default:   w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)      r_state <= ST_IDLE;
        else if (i_enb) r_state <= w_state_nx;
    end

    always_comb begin
        w_rest_nx = r_rest;
        for (int v = 0; v < QUEUE_QUANTITY; v++) begin
            if (w_start) begin
                w_rest_nx[v] = i_cantidad[v*CW +: CW];
            end else begin
                if (w_send && w_gnt == VW'(v)) w_rest_nx[v] = r_rest[v] - CW'(1);
`ifdef QOS_INYECTOR_REINTENTO_EN
                // Overflow while a burst is live: owe one more word, net zero if sending now.
                if (i_error_full[v] && (r_state == ST_ENVIO || r_state == ST_ESPERA)) begin
                    if (w_send && w_gnt == VW'(v)) w_rest_nx[v] = r_rest[v];
                    else if (r_rest[v] != REST_MAX) w_rest_nx[v] = r_rest[v] + CW'(1);
                end
`endif
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rest    <= '0;
            r_seq     <= '0;
            r_pausado <= '0;
            r_ptr     <= '0;
            r_wr_en   <= 1'b0;
            r_vc      <= '0;
            r_data    <= '0;
            r_err     <= '0;
        end else if (!i_enb) begin
            r_wr_en <= 1'b0;
        end else begin
            r_rest  <= w_rest_nx;
            r_wr_en <= w_send;
            if (w_send) begin
                r_vc         <= w_gnt;
                r_data       <= DW'({w_gnt, r_seq[w_gnt]});
                r_seq[w_gnt] <= r_seq[w_gnt] + 2'd1;
                r_ptr        <= VW'((int'(w_gnt) + 1) % QUEUE_QUANTITY);
            end
            if (w_start) begin
                r_seq     <= '0;
                r_ptr     <= '0;
                r_pausado <= '0;
                r_err     <= '0;
            end else begin
                r_pausado <= (r_pausado & ~i_continuar) | i_pausa;
                if (|i_error_full && r_err != 4'hF) r_err <= r_err + 4'd1;
            end
        end
    end

    assign o_wr_en     = r_wr_en;
    assign o_vc_id     = r_vc;
    assign o_data_word = r_data;
    assign o_ocupado   = (r_state != ST_IDLE);
    assign o_listo     = (r_state == ST_FIN);
    assign o_errores   = r_err;
endmodule
